// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor.
// One full-adder cell and a carry flop process the operands LSB-first, one bit
// per clock. Subtraction feeds the cell with ~b and a carry-in of 1, so that
// a - b is computed as a + ~b + 1.
// Result, carry_out and overflow update only on entry to DONE and hold until
// the next completion.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic             sum_bit;
    logic             carry_next;
    logic [CNT_W-1:0] count;

    function automatic logic fa_sum(input logic x, input logic y, input logic cin);
        return x ^ y ^ cin;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic cin);
        return (x & y) | (x & cin) | (y & cin);
    endfunction

    // Full-adder cell on the current operand LSBs; the new sum bit enters the accumulator at the MSB
    always_comb begin
        sum_bit             = fa_sum(op_a[0], op_b[0], carry);
        carry_next          = fa_carry(op_a[0], op_b[0], carry);
        acc_next            = acc >> 1;
        acc_next[WIDTH-1]   = sum_bit;
    end

    // Control FSM plus operand/accumulator shift registers and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            count     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub;
                        count <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    acc   <= acc_next;
                    carry <= carry_next;
                    count <= count + CNT_W'(1);
                    if (count == LAST_BIT) begin
                        // carry still holds the carry into the MSB at this edge
                        result    <= acc_next;
                        carry_out <= carry_next;
                        overflow  <= carry ^ carry_next;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: an 8-bit and a 1-bit instance share
// clock and reset. Drivers push expected results computed with plain integer
// arithmetic; per-instance monitors pop and compare whenever done is seen.
module tb_serial_add_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       start8, sub8, busy8, done8, carry8, ovf8;
    logic [7:0] a8, b8, res8;
    logic       start1, sub1, busy1, done1, carry1, ovf1;
    logic [0:0] a1, b1, res1;

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .carry_out(carry8), .overflow(ovf8)
    );

    serial_add_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(res1), .carry_out(carry1), .overflow(ovf1)
    );

    int     tests = 0;
    int     fails = 0;
    longint cyc   = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        longint res;
        bit     c;
        bit     ov;
        longint due;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    exp_t e8, e1;
    logic [9:0] held8 = '0;
    logic [2:0] held1 = '0;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: unsigned sum/difference for result and carry, signed range test for overflow
    function automatic exp_t model(input int w, input longint a, input longint b,
                                   input bit s, input longint due);
        exp_t   e;
        longint mask = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua = a & mask;
        longint ub = b & mask;
        longint sa = (ua >= half) ? ua - (longint'(1) << w) : ua;
        longint sb = (ub >= half) ? ub - (longint'(1) << w) : ub;
        longint sr;
        if (!s) begin
            e.res = (ua + ub) & mask;
            e.c   = ((ua + ub) > mask);
            sr    = sa + sb;
        end else begin
            e.res = (ua - ub) & mask;
            e.c   = (ua >= ub);
            sr    = sa - sb;
        end
        e.ov  = (sr < -half) || (sr > half - 1);
        e.due = due;
        return e;
    endfunction

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        if (!rst_n) begin
            held8 = '0;
        end else begin
            check("busy_done_excl8", longint'(busy8 & done8), 0);
            if (done8) begin
                if (q8.size() == 0) begin
                    check("unexpected_done8", longint'(done8), 0);
                end else begin
                    e8 = q8.pop_front();
                    check("result8", longint'(res8), e8.res);
                    check("carry8", longint'(carry8), longint'(e8.c));
                    check("ovf8", longint'(ovf8), longint'(e8.ov));
                    check("latency8", cyc, e8.due);
                end
                held8 = {res8, carry8, ovf8};
            end else begin
                check("hold8", longint'({res8, carry8, ovf8}), longint'(held8));
            end
        end
    end

    // Monitor for the 1-bit instance
    always @(negedge clk) begin
        if (!rst_n) begin
            held1 = '0;
        end else begin
            check("busy_done_excl1", longint'(busy1 & done1), 0);
            if (done1) begin
                if (q1.size() == 0) begin
                    check("unexpected_done1", longint'(done1), 0);
                end else begin
                    e1 = q1.pop_front();
                    check("result1", longint'(res1), e1.res);
                    check("carry1", longint'(carry1), longint'(e1.c));
                    check("ovf1", longint'(ovf1), longint'(e1.ov));
                    check("latency1", cyc, e1.due);
                end
                held1 = {res1, carry1, ovf1};
            end else begin
                check("hold1", longint'({res1, carry1, ovf1}), longint'(held1));
            end
        end
    end

    // Called at a negedge while the DUT is IDLE or DONE; returns one negedge later
    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic s);
        a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
        q8.push_back(model(8, a, b, s, cyc + 1 + 8));
        @(negedge clk);
        start8 = 1'b0;
        check("busy_after_start8", longint'(busy8), 1);
    endtask

    task automatic wait_done8;
        int n = 0;
        while (!done8 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("done8_timeout", longint'(done8), 1);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s);
        drive8(a, b, s);
        wait_done8();
        @(negedge clk);
    endtask

    task automatic drive1(input logic a, input logic b, input logic s);
        a1 = a; b1 = b; sub1 = s; start1 = 1'b1;
        q1.push_back(model(1, longint'(a), longint'(b), s, cyc + 1 + 1));
        @(negedge clk);
        start1 = 1'b0;
        check("busy_after_start1", longint'(busy1), 1);
    endtask

    task automatic wait_done1;
        int n = 0;
        while (!done1 && n < 6) begin
            @(negedge clk);
            n++;
        end
        check("done1_timeout", longint'(done1), 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy8"}, longint'(busy8), 0);
        check({tag, "_done8"}, longint'(done8), 0);
        check({tag, "_result8"}, longint'(res8), 0);
        check({tag, "_carry8"}, longint'(carry8), 0);
        check({tag, "_ovf8"}, longint'(ovf8), 0);
        check({tag, "_busy1"}, longint'(busy1), 0);
        check({tag, "_done1"}, longint'(done1), 0);
        check({tag, "_result1"}, longint'({res1, carry1, ovf1}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Directed add/sub cases, including carry and signed overflow corners
        run8(8'h05, 8'h03, 1'b0);
        run8(8'hFF, 8'h01, 1'b0);
        run8(8'h7F, 8'h01, 1'b0);
        run8(8'h05, 8'h03, 1'b1);
        run8(8'h03, 8'h05, 1'b1);
        run8(8'h80, 8'h01, 1'b1);
        run8(8'h00, 8'h00, 1'b1);

        // start during RUN must be ignored; then start held through DONE
        drive8(8'h05, 8'h03, 1'b0);
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; sub8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8();
        drive8(8'h40, 8'h30, 1'b1);
        wait_done8();
        @(negedge clk);

        // Asynchronous reset in the middle of RUN aborts the operation
        drive8(8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("abort");
        q8.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run8(8'h12, 8'h34, 1'b0);

        // Random operations, randomly back-to-back or separated by an idle cycle
        for (int i = 0; i < 30; i++) begin
            drive8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            wait_done8();
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        @(negedge clk);

        // WIDTH=1: exhaustive full-adder truth table, then back-to-back random ops
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            drive1(v[2], v[1], v[0]);
            wait_done1();
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            drive1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_done1();
        end

        repeat (4) @(negedge clk);
        check("q8_drained", longint'(q8.size()), 0);
        check("q1_drained", longint'(q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
